// File: rtl/instr_mem_resp_pkg.sv
// Shared types and defaults for the instruction memory responder.
// Holds the response record and the default memory geometry.
package instr_mem_resp_pkg;

   localparam int unsigned DEF_DEPTH_WORDS = 4096;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

endpackage

// File: rtl/instr_mem_resp_sram.sv
// Word storage: one preload write port and one synchronous read port.
// A read and a write to the same word on one edge return the old word.
module imem_sram #(
   parameter int unsigned DEPTH_WORDS = 4096,
   localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction fetch responder: grants requests, reads storage in the grant
// edge, and returns one in-order response LATENCY cycles after each grant.
module instr_mem_resp
   import instr_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS     = DEF_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   instr_req,
   input  logic [31:0]                            instr_addr,
   output logic                                   instr_gnt,
   output logic [31:0]                            instr_rdata,
   output logic                                   instr_err,
   output logic                                   instr_valid,
   input  logic                                   gnt_stall,
   input  logic                                   ld_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0]         ld_addr,
   input  logic [31:0]                            ld_wdata,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

   localparam int unsigned AW     = $clog2(DEPTH_WORDS);
   localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
   localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
   localparam logic [32:0] SPAN33 = 33'(DEPTH_WORDS) << 2;

   logic [32:0]        addr33, off33;
   logic               in_range;
   logic [AW-1:0]      rd_idx;
   logic               unused_bits;
   logic [31:0]        sram_rdata, last_data;
   logic [LATENCY-1:0] vld_pipe_q, err_pipe_q;
   logic [OW-1:0]      os_q, os_d;
   resp_t              resp;

   // 33-bit compare so a top-of-space address can never wrap into range
   assign addr33      = {1'b0, instr_addr[31:2], 2'b00};
   assign off33       = addr33 - BASE33;
   assign in_range    = (addr33 >= BASE33) && (off33 < SPAN33);
   assign rd_idx      = off33[AW+1:2];
   assign unused_bits = ^{off33[32:AW+2], off33[1:0], instr_addr[1:0]};

   assign instr_gnt = instr_req & ~gnt_stall & ((os_q < MAX_OS) | instr_valid);

   imem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
      .clk     (clk),
      .we_i    (ld_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_wdata),
      .re_i    (instr_gnt & in_range),
      .raddr_i (rd_idx),
      .rdata_o (sram_rdata)
   );

   // SRAM output lines up with pipeline stage 1; later stages only delay data
   if (LATENCY == 1) begin : g_nodly
      assign last_data = sram_rdata;
   end else begin : g_dly
      logic [LATENCY-2:0][31:0] dly_q;
      always_ff @(posedge clk) begin
         dly_q[0] <= sram_rdata;
         for (int k = 1; k < LATENCY - 1; k++) dly_q[k] <= dly_q[k-1];
      end
      assign last_data = dly_q[LATENCY-2];
   end

   always_comb begin
      os_d = os_q;
      if (instr_gnt && !instr_valid)      os_d = os_q + OW'(1);
      else if (!instr_gnt && instr_valid) os_d = os_q - OW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q <= '0;
         err_pipe_q <= '0;
         os_q       <= '0;
      end else begin
         vld_pipe_q[0] <= instr_gnt;
         err_pipe_q[0] <= instr_gnt & ~in_range;
         for (int k = 1; k < LATENCY; k++) begin
            vld_pipe_q[k] <= vld_pipe_q[k-1];
            err_pipe_q[k] <= err_pipe_q[k-1];
         end
         os_q <= os_d;
      end
   end

   always_comb begin
      resp.valid = vld_pipe_q[LATENCY-1];
      resp.err   = vld_pipe_q[LATENCY-1] & err_pipe_q[LATENCY-1];
      resp.rdata = (resp.valid && !resp.err) ? last_data : 32'h0;
   end

   assign instr_valid = resp.valid;
   assign instr_err   = resp.err;
   assign instr_rdata = resp.rdata;
   assign outstanding = os_q;

endmodule

// File: tb/tb_instr_mem_resp.sv
// Directed bench: instance A (LATENCY 1, base 0, 4096 words) and
// instance B (LATENCY 3, base 0x1000, 16 words) with hand-computed results.
module tb_instr_mem_resp;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        a_req, a_stall, a_ldwe, a_gnt, a_err, a_valid;
   logic [31:0] a_addr, a_ldwd, a_rdata;
   logic [11:0] a_ldaddr;
   logic [1:0]  a_os;

   logic        b_req, b_stall, b_ldwe, b_gnt, b_err, b_valid;
   logic [31:0] b_addr, b_ldwd, b_rdata;
   logic [3:0]  b_ldaddr;
   logic [1:0]  b_os;

   int checks = 0;
   int errors = 0;

   instr_mem_resp #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
      .clk(clk), .reset_n(rst_n), .instr_req(a_req), .instr_addr(a_addr), .instr_gnt(a_gnt),
      .instr_rdata(a_rdata), .instr_err(a_err), .instr_valid(a_valid), .gnt_stall(a_stall),
      .ld_we(a_ldwe), .ld_addr(a_ldaddr), .ld_wdata(a_ldwd), .outstanding(a_os));

   instr_mem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
      .clk(clk), .reset_n(rst_n), .instr_req(b_req), .instr_addr(b_addr), .instr_gnt(b_gnt),
      .instr_rdata(b_rdata), .instr_err(b_err), .instr_valid(b_valid), .gnt_stall(b_stall),
      .ld_we(b_ldwe), .ld_addr(b_ldaddr), .ld_wdata(b_ldwd), .outstanding(b_os));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] pa [8];
   logic [31:0] pd [8];
   logic [31:0] a_exp [4];

   initial begin
      pa = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd8, 12'hFFF};
      pd = '{32'd11, 32'd22, 32'd33, 32'd44, 32'h1010_1010, 32'h1234_5678, 32'hA0A0_0008, 32'hCAFE_F00D};
      a_exp = '{32'd11, 32'd22, 32'd33, 32'd44};
      rst_n = 1'b0;
      {a_req, a_stall, a_ldwe, b_req, b_stall, b_ldwe} = '0;
      a_addr = '0; a_ldwd = '0; a_ldaddr = '0;
      b_addr = '0; b_ldwd = '0; b_ldaddr = '0;

      // reset state: grant still follows the request, responses held off
      #2 a_req = 1'b1;
      #1;
      chk("rst_gnt", a_gnt, 1);
      chk("rst_vld", a_valid, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_err", a_err, 0);
      chk("rst_os", a_os, 0);
      chk("rst_b_vld", b_valid, 0);
      a_req = 1'b0;
      step(); step();
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step();
         b_ldwe = 1'b1; b_ldaddr = 4'(i); b_ldwd = 32'hB000_0000 + 32'(i);
         a_ldwe = (i < 8);
         if (i < 8) begin a_ldaddr = pa[i]; a_ldwd = pd[i]; end
      end
      step();
      a_ldwe = 1'b0; b_ldwe = 1'b0;

      // back-to-back stream, latency 1
      step(); a_req = 1'b1; a_addr = 32'h0; #2;
      chk("bb_gnt0", a_gnt, 1);
      chk("bb_vld0", a_valid, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k < 4) a_addr = 32'(4 * k); else a_req = 1'b0;
         #2;
         chk("bb_gnt", a_gnt, (k < 4) ? 32'd1 : 32'd0);
         chk("bb_vld", a_valid, 1);
         chk("bb_rdata", a_rdata, a_exp[k-1]);
         chk("bb_err", a_err, 0);
         chk("bb_os", a_os, 1);
      end
      step(); #2;
      chk("bb_idle_vld", a_valid, 0);
      chk("bb_idle_rdata", a_rdata, 0);
      chk("bb_idle_os", a_os, 0);

      // stall with address change; granted-cycle address wins
      step(); a_req = 1'b1; a_addr = 32'h10; a_stall = 1'b1; #2;
      chk("st_gnt0", a_gnt, 0);
      step(); #2;
      chk("st_gnt1", a_gnt, 0);
      chk("st_vld1", a_valid, 0);
      step(); a_addr = 32'h20; #2;
      chk("st_gnt2", a_gnt, 0);
      step(); a_stall = 1'b0; #2;
      chk("st_gnt3", a_gnt, 1);
      step(); a_req = 1'b0; #2;
      chk("st_vld", a_valid, 1);
      chk("st_rdata", a_rdata, 32'hA0A0_0008);
      chk("st_err", a_err, 0);

      // range boundaries at base 0
      step(); a_req = 1'b1; a_addr = 32'h4000; #2;
      chk("rg_gnt", a_gnt, 1);
      step(); a_addr = 32'hFFFF_FFFC; #2;
      chk("rg_4000_vld", a_valid, 1);
      chk("rg_4000_err", a_err, 1);
      chk("rg_4000_rdata", a_rdata, 0);
      step(); a_addr = 32'h3FFC; #2;
      chk("rg_top_err", a_err, 1);
      chk("rg_top_rdata", a_rdata, 0);
      step(); a_req = 1'b0; #2;
      chk("rg_3ffc_err", a_err, 0);
      chk("rg_3ffc_rdata", a_rdata, 32'hCAFE_F00D);
      step(); #2;
      chk("rg_idle_err", a_err, 0);

      // preload in grant cycle: read-first
      step(); a_req = 1'b1; a_addr = 32'h14;
      a_ldwe = 1'b1; a_ldaddr = 12'd5; a_ldwd = 32'hDEAD_BEEF; #2;
      chk("rf_gnt", a_gnt, 1);
      step(); a_ldwe = 1'b0; #2;
      chk("rf_old", a_rdata, 32'h1234_5678);
      step(); a_req = 1'b0; #2;
      chk("rf_new", a_rdata, 32'hDEAD_BEEF);

      // B: latency 3, two outstanding max
      step(); b_req = 1'b1; b_addr = 32'h1000; #2;
      chk("ml_gnt0", b_gnt, 1);
      chk("ml_os0", b_os, 0);
      step(); b_addr = 32'h1004; #2;
      chk("ml_gnt1", b_gnt, 1);
      chk("ml_os1", b_os, 1);
      step(); b_addr = 32'h1008; #2;
      chk("ml_gnt2", b_gnt, 0);
      chk("ml_os2", b_os, 2);
      step(); #2;
      chk("ml_gnt3", b_gnt, 1);
      chk("ml_vld3", b_valid, 1);
      chk("ml_rd3", b_rdata, 32'hB000_0000);
      chk("ml_os3", b_os, 2);
      step(); b_addr = 32'h100C; #2;
      chk("ml_gnt4", b_gnt, 1);
      chk("ml_rd4", b_rdata, 32'hB000_0001);
      step(); b_addr = 32'h1010; #2;
      chk("ml_gnt5", b_gnt, 0);
      chk("ml_vld5", b_valid, 0);
      chk("ml_os5", b_os, 2);
      step(); b_req = 1'b0; #2;
      chk("ml_rd6", b_rdata, 32'hB000_0002);
      chk("ml_os6", b_os, 2);
      step(); #2;
      chk("ml_rd7", b_rdata, 32'hB000_0003);
      chk("ml_os7", b_os, 1);
      step(); #2;
      chk("ml_vld8", b_valid, 0);
      chk("ml_os8", b_os, 0);

      // B: nonzero base boundaries
      step(); b_req = 1'b1; b_addr = 32'h0FFC; #2;
      chk("bb_lo_gnt", b_gnt, 1);
      step(); b_addr = 32'h103C; #2;
      step(); b_req = 1'b0; #2;
      step(); #2;
      chk("bb_lo_vld", b_valid, 1);
      chk("bb_lo_err", b_err, 1);
      chk("bb_lo_rdata", b_rdata, 0);
      step(); #2;
      chk("bb_hi_err", b_err, 0);
      chk("bb_hi_rdata", b_rdata, 32'hB000_000F);
      step(); b_req = 1'b1; b_addr = 32'h1040; #2;
      chk("bb_end_gnt", b_gnt, 1);
      step(); b_req = 1'b0;
      step(); step(); #2;
      chk("bb_end_vld", b_valid, 1);
      chk("bb_end_err", b_err, 1);
      step(); #2;
      chk("bb_end_os", b_os, 0);

      // reset with two in flight
      step(); b_req = 1'b1; b_addr = 32'h1004;
      step(); b_addr = 32'h1008;
      step(); b_req = 1'b0; #2;
      chk("mr_os_pre", b_os, 2);
      rst_n = 1'b0; #1;
      chk("mr_os_rst", b_os, 0);
      chk("mr_vld_rst", b_valid, 0);
      step(); step();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(); #2;
         chk("mr_no_vld", b_valid, 0);
         chk("mr_os", b_os, 0);
      end
      step(); b_req = 1'b1; b_addr = 32'h100C; #2;
      chk("mr_gnt", b_gnt, 1);
      step(); b_req = 1'b0;
      step(); step(); #2;
      chk("mr_vld", b_valid, 1);
      chk("mr_rdata", b_rdata, 32'hB000_0003);
      step(); #2;
      chk("mr_vld_off", b_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_resp.md
INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096: storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 1, legal 1..4: cycles from grant to valid.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, legal 1..LATENCY+1: granted-but-unanswered limit.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port instr_req  input  1  fetch request from initiator.
REQ-008 SHALL have port instr_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port instr_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have port instr_rdata  output  32  read word.
REQ-011 SHALL have port instr_err  output  1  response error.
REQ-012 SHALL have port instr_valid  output  1  response valid, one cycle per granted request.
REQ-013 SHALL have port gnt_stall  input  1  when high, forces instr_gnt low (wait-state injection).
REQ-014 SHALL have port ld_we  input  1  preload write enable.
REQ-015 SHALL have port ld_addr  input  $clog2(DEPTH_WORDS)  preload word index.
REQ-016 SHALL have port ld_wdata  input  32  preload data.
REQ-017 SHALL have port outstanding  output  $clog2(MAX_OUTSTANDING+1)  in-flight request count.

Function
REQ-018 Grant: instr_gnt SHALL equal instr_req & ~gnt_stall & (outstanding < MAX_OUTSTANDING | instr_valid), combinationally in the same cycle.
REQ-019 Address SHALL be sampled only in the grant cycle; changes while ungranted are legal and the granted-cycle value wins.
REQ-020 Each grant SHALL produce exactly one instr_valid pulse exactly LATENCY cycles later; responses SHALL be in grant order.
REQ-021 Back-to-back grants SHALL be supported: grant and valid in the same cycle, one grant per cycle sustained.
REQ-022 outstanding SHALL increment on grant only, decrement on valid only, hold when both or neither occur.
REQ-023 In-range address (BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS): rdata = mem[(addr-BASE_ADDR)>>2], err = 0.
REQ-024 Out-of-range address: valid still returned at LATENCY, err = 1, rdata = 32'h0, storage unread.
REQ-025 Address compare SHALL use 33-bit arithmetic; no wrap at 32'hFFFF_FFFC aliases into range.
REQ-026 While instr_valid is low, instr_rdata SHALL be 32'h0 and instr_err SHALL be 0.
REQ-027 Preload write SHALL take effect at the clock edge; same-cycle read of same word at grant SHALL return old data (read-first).
REQ-028 Response pipeline SHALL be a LATENCY-deep shift of {valid, err, index}; the storage read occurs in the grant cycle's edge, with remaining stages delaying data.

Reset
REQ-029 On reset_n low: instr_gnt follows REQ-018 with outstanding = 0; instr_valid = 0, instr_rdata = 0, instr_err = 0, outstanding = 0, all pipeline valid bits cleared.
REQ-030 Reset mid-operation SHALL discard all in-flight responses; none SHALL appear after reset release.
REQ-031 Storage contents SHALL NOT be reset.

Structure
REQ-032 Shared package SHALL hold the response struct {valid, err, rdata} and the default BASE_ADDR/DEPTH constants.
REQ-033 Storage SHALL be sub-module imem_sram: one write port (ld_*), one synchronous read port, read-first.
REQ-034 Target size 120-400 lines of RTL; no latches, no combinational path from instr_addr to instr_valid.

Verification
REQ-035 Preload mem[0..3] = 11,22,33,44; LATENCY=1; req addr 0,4,8,12 held continuously -> gnt 4 consecutive cycles, valid next cycle each, rdata 11,22,33,44, err 0.
REQ-036 LATENCY=3, MAX_OUTSTANDING=2, req held 6 cycles -> gnt cycles 0,1, stall cycle 2, gnt resumes cycle 3 with valid; outstanding never exceeds 2.
REQ-037 gnt_stall high 3 cycles while req high, addr changes 0x10->0x20 during stall -> gnt in cycle 3 only, response is word at 0x20.
REQ-038 DEPTH_WORDS=4096, BASE 0: addr 0x4000 and 0xFFFF_FFFC -> valid with err=1, rdata=0; addr 0x3FFC -> err=0.
REQ-039 ld_we to word 5 with 0xDEAD_BEEF in grant cycle of addr 0x14 (old 0x1234_5678) -> response 0x1234_5678; next read -> 0xDEAD_BEEF.
REQ-040 Assert reset_n low with 2 requests in flight, release -> no valid pulse afterward, outstanding = 0, next request served normally.
